// File: rtl/run_detector_pkg.sv
// Shared definitions for the serial run detector: mode encodings and the
// polarity-enable decode used by both the output and the hit pulse.
package run_detector_pkg;

  // Polarity enable: which run polarities are reported.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_ONE  = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // True when the given mode reports runs of polarity b.
  function automatic logic mode_enables(input logic [1:0] m, input logic b);
    mode_e md;
    md = mode_e'(m);
    if (md == MODE_BOTH) begin
      return 1'b1;
    end
    if (b) begin
      return md == MODE_ONE;
    end
    return md == MODE_ZERO;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Priority: rst > clr > load > inc. Counting stops at MAX.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register: clear/load override a saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/run_detector.sv
// Serial run detector: reports RUN_LEN consecutive identical valid bits of
// the polarities enabled by mode, with optional overlapping detection and a
// saturating count of completed runs.
module run_detector
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clear_cnt,
  output logic             out,
  output logic             out_bit,
  output logic             hit_pulse,
  output logic [CNT_W-1:0] hit_count
);

  localparam int               RUN_W   = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(RUN_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             started;
  logic             last_bit;
  logic [RUN_W-1:0] run;

  logic same_bit;
  logic run_full;
  logic new_run;
  logic run_load;
  logic run_inc;
  logic pulse_d;

  // Next-state decode for the run tracker and the hit pulse.
  always_comb begin
    same_bit = started && (in == last_bit);
    run_full = (run == RUN_MAX);
    new_run  = in_valid && !same_bit;
    // Non-overlapping mode restarts counting on the bit after a full run.
    run_load = new_run || (in_valid && same_bit && run_full && !overlap);
    run_inc  = in_valid && same_bit && !run_full;
    // Pulse only on the sample that completes a run; a held full run in
    // overlap mode never re-enters RUN_PRE, so it cannot re-pulse.
    pulse_d  = in_valid && same_bit && (run == RUN_PRE) && mode_enables(mode, in);
  end

  // Control state: started flag, run polarity and the registered hit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      started   <= 1'b0;
      last_bit  <= 1'b0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= pulse_d;
      if (new_run) begin
        started  <= 1'b1;
        last_bit <= in;
      end
    end
  end

  sat_counter #(
    .W   (RUN_W),
    .MAX (RUN_MAX)
  ) u_run_cnt (
    .clk      (clk),
    .rst      (reset),
    .clr      (1'b0),
    .load     (run_load),
    .load_val (RUN_ONE),
    .inc      (run_inc),
    .cnt      (run)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_hit_cnt (
    .clk      (clk),
    .rst      (reset),
    .clr      (clear_cnt),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .inc      (hit_pulse),
    .cnt      (hit_count)
  );

  // Moore outputs: registered state decoded with the live mode only.
  assign out     = started && run_full && mode_enables(mode, last_bit);
  assign out_bit = last_bit;

endmodule

// File: tb/tb_run_detector.sv
// Directed self-checking bench for run_detector (RUN_LEN=4, CNT_W=8).
module tb_run_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in;
  logic [1:0] mode;
  logic       overlap;
  logic       clear_cnt;
  logic       out;
  logic       out_bit;
  logic       hit_pulse;
  logic [7:0] hit_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       vld;
    logic       din;
    logic [1:0] md;
    logic       ov;
    logic       clr;
    logic       e_out;
    logic       e_bit;
    logic       e_pulse;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  run_detector #(.RUN_LEN(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .mode      (mode),
    .overlap   (overlap),
    .clear_cnt (clear_cnt),
    .out       (out),
    .out_bit   (out_bit),
    .hit_pulse (hit_pulse),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic d, input logic [1:0] m,
                     input logic o, input logic c, input logic eo, input logic eb,
                     input logic ep, input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.md = m; t.ov = o; t.clr = c;
    t.e_out = eo; t.e_bit = eb; t.e_pulse = ep; t.e_cnt = ec;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, let the edge pass, sample 1 time unit later.
  task automatic cyc(input logic r, input logic v, input logic d, input logic c);
    reset = r; in_valid = v; in = d; clear_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic eo, input logic eb,
                         input logic ep, input logic [7:0] ec);
    chk({tag, " out"}, int'(out), int'(eo));
    chk({tag, " out_bit"}, int'(out_bit), int'(eb));
    chk({tag, " hit_pulse"}, int'(hit_pulse), int'(ep));
    chk({tag, " hit_count"}, int'(hit_count), int'(ec));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in = 1'b0; mode = 2'b00; overlap = 1'b0; clear_cnt = 1'b0;

    // Overlapping zero run, both polarities: r v d md ov clr | out bit pulse cnt
    add(1, 1, 1, 2'b11, 1, 1,  0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 1, 0,  0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 1, 0,  0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 1, 0,  0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 1, 0,  1, 0, 1, 0);
    add(0, 1, 0, 2'b11, 1, 0,  1, 0, 0, 1);
    add(0, 1, 1, 2'b11, 1, 0,  0, 1, 0, 1);
    // Non-overlapping ones (reset wins over valid and clear)
    add(1, 1, 1, 2'b10, 0, 1,  0, 0, 0, 0);
    add(0, 1, 1, 2'b10, 0, 0,  0, 1, 0, 0);
    add(0, 1, 1, 2'b10, 0, 0,  0, 1, 0, 0);
    add(0, 1, 1, 2'b10, 0, 0,  0, 1, 0, 0);
    add(0, 1, 1, 2'b10, 0, 0,  1, 1, 1, 0);
    add(0, 1, 1, 2'b10, 0, 0,  0, 1, 0, 1);
    add(0, 1, 1, 2'b10, 0, 0,  0, 1, 0, 1);
    add(0, 1, 1, 2'b10, 0, 0,  0, 1, 0, 1);
    add(0, 1, 1, 2'b10, 0, 0,  1, 1, 1, 1);
    add(0, 1, 0, 2'b10, 0, 0,  0, 0, 0, 2);
    // Zero-only mode: run of ones is ignored
    add(1, 0, 0, 2'b01, 1, 0,  0, 0, 0, 0);
    add(0, 1, 1, 2'b01, 1, 0,  0, 1, 0, 0);
    add(0, 1, 1, 2'b01, 1, 0,  0, 1, 0, 0);
    add(0, 1, 1, 2'b01, 1, 0,  0, 1, 0, 0);
    add(0, 1, 1, 2'b01, 1, 0,  0, 1, 0, 0);
    add(0, 1, 1, 2'b01, 1, 0,  0, 1, 0, 0);
    // Zeros separated by invalid gaps: state holds, exactly one pulse
    add(0, 1, 0, 2'b01, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 2'b01, 1, 0,  0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 2'b01, 1, 0,  0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 2'b01, 1, 0,  0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 1, 0,  1, 0, 1, 0);
    add(0, 0, 1, 2'b01, 1, 0,  1, 0, 0, 1);
    add(0, 0, 0, 2'b01, 1, 0,  1, 0, 0, 1);
    // Mode change mid-run affects out only
    add(0, 0, 0, 2'b10, 1, 0,  0, 0, 0, 1);
    add(0, 0, 0, 2'b00, 1, 0,  0, 0, 0, 1);
    add(0, 0, 0, 2'b11, 1, 0,  1, 0, 0, 1);
    add(0, 1, 0, 2'b11, 1, 0,  1, 0, 0, 1);
    // Clear of the hit counter
    add(0, 0, 0, 2'b11, 1, 1,  1, 0, 0, 0);

    foreach (vecs[i]) begin
      mode = vecs[i].md;
      overlap = vecs[i].ov;
      cyc(vecs[i].rst, vecs[i].vld, vecs[i].din, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_bit,
              vecs[i].e_pulse, vecs[i].e_cnt);
    end

    // Saturation: 255 non-overlapping runs of ones, then one more run.
    mode = 2'b11; overlap = 1'b0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 255 * 4; k++) cyc(0, 1, 1, 0);
    chk("sat last pulse", int'(hit_pulse), 1);
    chk("sat pre count", int'(hit_count), 254);
    cyc(0, 0, 0, 0);
    chk("sat count 255", int'(hit_count), 255);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0);
    chk("sat extra pulse", int'(hit_pulse), 1);
    cyc(0, 0, 0, 0);
    chk("sat hold 255", int'(hit_count), 255);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0);
    chk("clr pulse", int'(hit_pulse), 1);
    cyc(0, 0, 0, 1);
    chk("clr beats inc", int'(hit_count), 0);
    cyc(0, 0, 0, 0);
    chk("clr stays 0", int'(hit_count), 0);

    // Reset discards a run in progress.
    mode = 2'b10; overlap = 1'b1;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0);
      chk($sformatf("pre-rst out %0d", k), int'(out), 0);
    end
    cyc(1, 1, 1, 0);
    chk_all("rst mid-run", 0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    chk_all("post-rst first", 0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk_all("post-rst third", 0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk_all("post-rst fourth", 1, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
